// File: rtl/ad2512_cfg_pkg.sv
// Shared types and constants for the AD2512 register-configuration sequencer.
package ad2512_cfg_pkg;

    localparam int CFG_FRAME_W = 24;
    localparam int CFG_CNT_W   = 17;
    localparam logic [CFG_FRAME_W-1:0] CFG_END_MARKER = 24'hFFFFFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PWRUP    = 3'd1,
        FETCH    = 3'd2,
        REQ      = 3'd3,
        WAIT_ACK = 3'd4,
        GAP      = 3'd5,
        DONE     = 3'd6,
        ERR      = 3'd7
    } cfg_state_e;

    function automatic logic is_end_marker(input logic [CFG_FRAME_W-1:0] word);
        return (word == CFG_END_MARKER);
    endfunction

endpackage

// File: rtl/ad2512_cfg_ctrl_if.sv
// LUT lookup and SPI write handshake between the config sequencer and its peers.
interface ad2512_cfg_ctrl_if
    import ad2512_cfg_pkg::*;
#(
    parameter int IDX_W = 10
);
    logic [IDX_W-1:0]       lut_index;
    logic [CFG_FRAME_W-1:0] lut_data;
    logic                   spi_req;
    logic [CFG_FRAME_W-1:0] spi_wdata;
    logic                   spi_ack;

    modport master (
        output lut_index, spi_req, spi_wdata,
        input  lut_data, spi_ack
    );

    modport slave (
        input  lut_index, spi_req, spi_wdata,
        output lut_data, spi_ack
    );
endinterface

// File: rtl/ad2512_cfg_ctrl_delay_cnt.sv
// Loadable down-counter that saturates at zero; zero_o flags an expired count.
module cfg_delay_cnt
    import ad2512_cfg_pkg::*;
#(
    parameter int W = CFG_CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins over decrement, and decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != {W{1'b0}})) begin
            cnt_d = cnt_q - ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/ad2512_cfg_ctrl.sv
// ADC configuration sequencer: walks the config LUT after a power-up wait and issues one
// SPI write per entry, with settle/gap delays, ack timeout and done/error reporting.
module ad2512_cfg_ctrl
    import ad2512_cfg_pkg::*;
#(
    parameter int LUT_SIZE    = 5,
    parameter int PWRUP_CYC   = 1000,
    parameter int RST_SETTLE  = 500,
    parameter int GAP_CYC     = 16,
    parameter int ACK_TIMEOUT = 65535,
    parameter int IDX_W       = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_start_i,
    ad2512_cfg_ctrl_if.master     bus,
    output logic                  cfg_busy_o,
    output logic                  cfg_done_o,
    output logic                  cfg_err_o,
    output logic [IDX_W-1:0]      cfg_err_idx_o
);
    localparam logic [CFG_CNT_W-1:0] PWRUP_LD  = CFG_CNT_W'(PWRUP_CYC - 1);
    localparam logic [CFG_CNT_W-1:0] SETTLE_LD = CFG_CNT_W'(RST_SETTLE + GAP_CYC - 1);
    localparam logic [CFG_CNT_W-1:0] GAP_LD    = CFG_CNT_W'(GAP_CYC - 1);
    localparam logic [CFG_CNT_W-1:0] ACK_LD    = CFG_CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0]     IDX_END   = IDX_W'(LUT_SIZE);
    localparam logic [IDX_W-1:0]     IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};

    if ((PWRUP_CYC < 1) || (GAP_CYC < 1) || (ACK_TIMEOUT < 1)) begin : g_bad_delay
        $fatal(1, "ad2512_cfg_ctrl: PWRUP_CYC, GAP_CYC and ACK_TIMEOUT must each be >= 1");
    end
    if ((LUT_SIZE >= (1 << IDX_W)) || (RST_SETTLE + GAP_CYC > (1 << CFG_CNT_W))) begin : g_bad_size
        $fatal(1, "ad2512_cfg_ctrl: LUT_SIZE or settle delay out of range");
    end

    cfg_state_e             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CFG_FRAME_W-1:0] wdata_q, wdata_d;
    logic                   req_q, req_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [IDX_W-1:0]       err_idx_q, err_idx_d;

    logic                   dly_load, dly_dec, dly_zero;
    logic [CFG_CNT_W-1:0]   dly_val;
    logic                   to_load, to_dec, to_zero;

    cfg_delay_cnt #(.W(CFG_CNT_W)) u_dly (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (dly_load),
        .load_val_i (dly_val),
        .dec_i      (dly_dec),
        .zero_o     (dly_zero)
    );

    cfg_delay_cnt #(.W(CFG_CNT_W)) u_timeout (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (to_load),
        .load_val_i (ACK_LD),
        .dec_i      (to_dec),
        .zero_o     (to_zero)
    );

    // Next-state and output decode for the configuration walk.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        req_d     = req_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        dly_load  = 1'b0;
        dly_val   = PWRUP_LD;
        dly_dec   = 1'b0;
        to_load   = 1'b0;
        to_dec    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_start_i) begin
                    idx_d    = {IDX_W{1'b0}};
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    dly_load = 1'b1;
                    dly_val  = PWRUP_LD;
                    state_d  = PWRUP;
                end else begin
                    state_d  = IDLE;
                end
            end
            PWRUP, GAP: begin
                if (dly_zero) begin
                    state_d = FETCH;
                end else begin
                    dly_dec = 1'b1;
                end
            end
            FETCH: begin
                if ((idx_q == IDX_END) || is_end_marker(bus.lut_data)) begin
                    state_d = DONE;
                end else begin
                    wdata_d = bus.lut_data;
                    req_d   = 1'b1;
                    to_load = 1'b1;
                    state_d = REQ;
                end
            end
            REQ, WAIT_ACK: begin
                // A same-cycle ack beats an expiring timeout.
                if (bus.spi_ack) begin
                    req_d    = 1'b0;
                    idx_d    = idx_q + IDX_ONE;
                    dly_load = 1'b1;
                    dly_val  = (idx_q == {IDX_W{1'b0}}) ? SETTLE_LD : GAP_LD;
                    state_d  = GAP;
                end else if (to_zero) begin
                    req_d     = 1'b0;
                    err_d     = 1'b1;
                    err_idx_d = idx_q;
                    state_d   = ERR;
                end else begin
                    to_dec  = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            ERR: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                req_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            idx_q     <= {IDX_W{1'b0}};
            wdata_q   <= {CFG_FRAME_W{1'b0}};
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_idx_q <= {IDX_W{1'b0}};
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            req_q     <= req_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign bus.lut_index = idx_q;
    assign bus.spi_req   = req_q;
    assign bus.spi_wdata = wdata_q;
    assign cfg_busy_o    = busy_q;
    assign cfg_done_o    = done_q;
    assign cfg_err_o     = err_q;
    assign cfg_err_idx_o = err_idx_q;

endmodule

// File: tb/tb_ad2512_cfg_ctrl.sv
// Directed bench for ad2512_cfg_ctrl: behavioural LUT plus an SPI slave that acks after a set delay.
module tb_ad2512_cfg_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_start;
    logic       cfg_busy, cfg_done, cfg_err;
    logic [9:0] cfg_err_idx;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [23:0] lut_mem [0:7];
    logic [23:0] frames [$];
    int          rise_q [$];
    int          ack_q  [$];

    logic        model_ack = 1'b0;
    logic        tb_ack;
    logic        prev_req  = 1'b0;
    int          req_age   = 0;
    int          ack_delay;
    logic [9:0]  hold_idx;
    int          start_edge;
    int          dummy_edge;

    ad2512_cfg_ctrl_if #(.IDX_W(10)) bus ();

    ad2512_cfg_ctrl #(
        .LUT_SIZE    (5),
        .PWRUP_CYC   (1000),
        .RST_SETTLE  (500),
        .GAP_CYC     (16),
        .ACK_TIMEOUT (100),
        .IDX_W       (10)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cfg_start_i   (cfg_start),
        .bus           (bus),
        .cfg_busy_o    (cfg_busy),
        .cfg_done_o    (cfg_done),
        .cfg_err_o     (cfg_err),
        .cfg_err_idx_o (cfg_err_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign bus.lut_data = (bus.lut_index < 10'd8) ? lut_mem[bus.lut_index[2:0]] : 24'h000000;
    assign bus.spi_ack  = model_ack | tb_ack;

    // SPI slave: acks in the ack_delay-th request cycle unless the index is withheld.
    always @(negedge clk) begin
        if (bus.spi_req && !prev_req) rise_q.push_back(cyc);
        prev_req <= bus.spi_req;
        if (bus.spi_req) begin
            if ((req_age + 1 == ack_delay) && (bus.lut_index != hold_idx)) begin
                model_ack <= 1'b1;
                frames.push_back(bus.spi_wdata);
                ack_q.push_back(cyc + 1);
            end else begin
                model_ack <= 1'b0;
            end
            req_age <= req_age + 1;
        end else begin
            model_ack <= 1'b0;
            req_age   <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(output int edge_no);
        @(negedge clk);
        cfg_start = 1'b1;
        edge_no   = cyc + 1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (cfg_busy && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, 32'(cfg_busy), 32'd0);
    endtask

    task automatic wait_acks(input int cnt, input string tag);
        int n = 0;
        while (ack_q.size() < cnt && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ackwait"}, 32'(ack_q.size() >= cnt), 32'd1);
    endtask

    task automatic clear_logs();
        frames.delete();
        rise_q.delete();
        ack_q.delete();
    endtask

    task automatic check_full_pass(input string tag);
        check({tag, "_nframes"}, 32'(frames.size()), 32'd5);
        check({tag, "_f0"}, 32'(frames[0]), 32'h000080);
        check({tag, "_f1"}, 32'(frames[1]), 32'h000100);
        check({tag, "_f2"}, 32'(frames[2]), 32'h000201);
        check({tag, "_f3"}, 32'(frames[3]), 32'h000304);
        check({tag, "_f4"}, 32'(frames[4]), 32'h000400);
        check({tag, "_done"}, 32'(cfg_done), 32'd1);
        check({tag, "_err"}, 32'(cfg_err), 32'd0);
    endtask

    initial begin
        lut_mem[0] = 24'h000080; lut_mem[1] = 24'h000100; lut_mem[2] = 24'h000201;
        lut_mem[3] = 24'h000304; lut_mem[4] = 24'h000400; lut_mem[5] = 24'h0005AA;
        lut_mem[6] = 24'h0006BB; lut_mem[7] = 24'h0007CC;
        rst = 1'b1; cfg_start = 1'b0; tb_ack = 1'b0;
        ack_delay = 30; hold_idx = 10'h3FF;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req",     32'(bus.spi_req),   32'd0);
        check("rst_busy",    32'(cfg_busy),      32'd0);
        check("rst_done",    32'(cfg_done),      32'd0);
        check("rst_err",     32'(cfg_err),       32'd0);
        check("rst_idx",     32'(bus.lut_index), 32'd0);
        check("rst_err_idx", 32'(cfg_err_idx),   32'd0);
        rst = 1'b0;

        // Nominal pass with timing
        clear_logs();
        pulse_start(start_edge);
        check("t1_busy", 32'(cfg_busy), 32'd1);
        wait_idle("t1");
        check_full_pass("t1");
        check("t1_idx_end", 32'(bus.lut_index), 32'd5);
        check("t2_first_req", 32'(rise_q[0] - start_edge), 32'd1001);
        check("t2_settle_gap", 32'(rise_q[1] - ack_q[0]), 32'd517);
        check("t2_gap_1_2",    32'(rise_q[2] - ack_q[1]), 32'd17);
        check("t2_gap_3_4",    32'(rise_q[4] - ack_q[3]), 32'd17);
        check("t2_nrises", 32'(rise_q.size()), 32'd5);

        // End marker at index 3
        lut_mem[3] = 24'hFFFFFF;
        clear_logs();
        pulse_start(start_edge);
        check("t3_done_clr", 32'(cfg_done), 32'd0);
        wait_idle("t3");
        check("t3_nframes", 32'(frames.size()), 32'd3);
        check("t3_f2",      32'(frames[2]), 32'h000201);
        check("t3_done",    32'(cfg_done), 32'd1);
        check("t3_idx",     32'(bus.lut_index), 32'd3);
        lut_mem[3] = 24'h000304;

        // Ack timeout on index 2, then a clean rerun
        hold_idx = 10'd2;
        clear_logs();
        pulse_start(start_edge);
        wait_idle("t4");
        check("t4_err",     32'(cfg_err),     32'd1);
        check("t4_err_idx", 32'(cfg_err_idx), 32'd2);
        check("t4_req",     32'(bus.spi_req), 32'd0);
        check("t4_done",    32'(cfg_done),    32'd0);
        check("t4_nframes", 32'(frames.size()), 32'd2);
        hold_idx = 10'h3FF;
        clear_logs();
        pulse_start(start_edge);
        check("t4_err_clr", 32'(cfg_err), 32'd0);
        wait_idle("t4r");
        check_full_pass("t4r");

        // Same-cycle ack, stray ack in GAP, start while busy
        ack_delay = 1;
        clear_logs();
        pulse_start(start_edge);
        wait_acks(1, "t5");
        repeat (5) @(negedge clk);
        tb_ack = 1'b1;
        @(negedge clk);
        tb_ack = 1'b0;
        check("t5_idx_after_stray", 32'(bus.lut_index), 32'd1);
        pulse_start(dummy_edge);
        wait_idle("t5");
        check_full_pass("t5");
        check("t5_nrises", 32'(rise_q.size()), 32'd5);
        check("t5_first_req", 32'(rise_q[0] - start_edge), 32'd1001);
        check("t5_settle_gap", 32'(rise_q[1] - ack_q[0]), 32'd517);

        // Reset during WAIT_ACK of index 1
        ack_delay = 30;
        clear_logs();
        pulse_start(start_edge);
        wait_acks(1, "t6");
        while (rise_q.size() < 2 && cyc < 90000) @(negedge clk);
        repeat (5) @(negedge clk);
        check("t6_pre_req", 32'(bus.spi_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_req",  32'(bus.spi_req),   32'd0);
        check("t6_busy", 32'(cfg_busy),      32'd0);
        check("t6_idx",  32'(bus.lut_index), 32'd0);
        rst = 1'b0;
        clear_logs();
        pulse_start(start_edge);
        wait_idle("t6r");
        check_full_pass("t6r");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
